// File: rtl/mem_sched_pkg.sv
// Shared encodings for the unified-memory access scheduler: FSM states,
// requester indices and the starvation counter width.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } schedState_e;

  localparam int REQ_STK  = 0;
  localparam int REQ_DAT  = 1;
  localparam int REQ_IFU  = 2;
  localparam int NREQ     = 3;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_sched_picker.sv
// Combinational fixed-priority picker (stack > data > fetch) with an
// override that hands the grant to fetch once it has starved long enough.
module mem_sched_picker
  import mem_sched_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic            force_ifu_i,
  output logic [NREQ-1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    if (force_ifu_i && req_i[REQ_IFU]) begin
      grant_o[REQ_IFU] = 1'b1;
    end else if (req_i[REQ_STK]) begin
      grant_o[REQ_STK] = 1'b1;
    end else if (req_i[REQ_DAT]) begin
      grant_o[REQ_DAT] = 1'b1;
    end else if (req_i[REQ_IFU]) begin
      grant_o[REQ_IFU] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_scheduler.sv
// Serialises stack, data and fetch accesses onto one synchronous memory with
// a registered request/done handshake; every output is decoded from flops.
module mem_access_scheduler
  import mem_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 8,
  parameter int DW           = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stk_req,
  input  logic          stk_we,
  input  logic [AW-1:0] stk_addr,
  input  logic [DW-1:0] stk_wdata,
  input  logic          dat_req,
  input  logic          dat_we,
  input  logic [AW-1:0] dat_addr,
  input  logic [DW-1:0] dat_wdata,
  input  logic          ifu_req,
  input  logic [AW-1:0] ifu_addr,
  output logic [2:0]    done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_LIMIT);

  schedState_e         state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;

  logic [NREQ-1:0] reqVec;
  logic [NREQ-1:0] pickGrant;
  logic            forceIfu;

  assign reqVec   = {ifu_req, dat_req, stk_req};
  assign forceIfu = (starveCnt_q == StarveMax);

  mem_sched_picker uPicker (
    .req_i       (reqVec),
    .force_ifu_i (forceIfu),
    .grant_o     (pickGrant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      starveCnt_q <= '0;
    end else begin
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|reqVec) state_d = S_ISSUE;
      S_ISSUE: state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Winner's request is captured only in IDLE, so requester inputs may change freely afterwards.
  always_comb begin
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    starveCnt_d = starveCnt_q;
    if (state_q == S_IDLE) begin
      if (!ifu_req || pickGrant[REQ_IFU]) begin
        starveCnt_d = '0;
      end else if (starveCnt_q < StarveMax) begin
        starveCnt_d = starveCnt_q + STARVE_W'(1);
      end
      if (|reqVec) begin
        grant_d = pickGrant;
        if (pickGrant[REQ_STK]) begin
          we_d    = stk_we;
          addr_d  = stk_addr;
          wdata_d = stk_wdata;
        end else if (pickGrant[REQ_DAT]) begin
          we_d    = dat_we;
          addr_d  = dat_addr;
          wdata_d = dat_wdata;
        end else begin
          we_d    = 1'b0;
          addr_d  = ifu_addr;
          wdata_d = '0;
        end
      end
    end
    if (state_q == S_WAIT) begin
      rdata_d = mem_rdata;
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = '0;
    case (state_q)
      S_ISSUE: begin
        mem_read  = !we_q;
        mem_write = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      S_RESP:  done = grant_q;
      default: ;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Scoreboard bench: a transaction-level arbiter/memory model predicts each memory
// access and done pulse; one monitor process compares them as the DUT presents them.
module tb_mem_access_scheduler;

  localparam int STARVE_LIMIT = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic          reqV[3];
  logic          weV[3];
  logic [AW-1:0] addrV[3];
  logic [DW-1:0] wdataV[3];

  logic [2:0]    done;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          memRead;
  logic          memWrite;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata;

  mem_access_scheduler #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .AW           (AW),
    .DW           (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stk_req   (reqV[0]),
    .stk_we    (weV[0]),
    .stk_addr  (addrV[0]),
    .stk_wdata (wdataV[0]),
    .dat_req   (reqV[1]),
    .dat_we    (weV[1]),
    .dat_addr  (addrV[1]),
    .dat_wdata (wdataV[1]),
    .ifu_req   (reqV[2]),
    .ifu_addr  (addrV[2]),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .mem_read  (memRead),
    .mem_write (memWrite),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_rdata (memRdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory seen by the DUT: read data appears the cycle after mem_read.
  logic [DW-1:0] simMem[256];
  always @(posedge clk) begin
    if (memWrite) simMem[memAddr] <= memWdata;
    if (memRead)  memRdata <= simMem[memAddr];
  end

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } memExp_t;

  typedef struct {
    int            cyc;
    logic [2:0]    done;
    logic [DW-1:0] rdata;
  } doneExp_t;

  memExp_t  memQ[$];
  doneExp_t doneQ[$];
  logic [DW-1:0] refMem[256];

  int nChecks = 0;
  int nPass = 0;
  int cyc = 0;
  int nextArb = 0;
  int grantCyc = -1;
  int starve = 0;
  int doneCount = 0;
  int pendCyc = 0;
  bit pendValid = 1'b0;
  logic [AW-1:0] pendAddr;
  logic [DW-1:0] pendData;
  logic [DW-1:0] lastRead = '0;

  memExp_t  mItem;
  doneExp_t dItem;
  int       winner;
  logic     winWe;
  logic [DW-1:0] readVal;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model and monitor share one process so queue pushes and pops never race.
  initial forever begin
    @(negedge clk or negedge reset);
    if (!reset) begin
      memQ.delete();
      doneQ.delete();
      nextArb   = 0;
      grantCyc  = -1;
      starve    = 0;
      lastRead  = '0;
      pendValid = 1'b0;
    end else begin
      cyc++;
      if (pendValid && cyc >= pendCyc) begin
        refMem[pendAddr] = pendData;
        pendValid = 1'b0;
      end

      checkOutput("busy", 32'(busy), 32'((cyc > grantCyc) && (cyc < nextArb)));
      if (memRead || memWrite) begin
        if (memQ.size() == 0) begin
          checkOutput("memUnexpected", 32'({memRead, memWrite}), 32'(0));
        end else begin
          mItem = memQ.pop_front();
          checkOutput("memCycle", 32'(cyc), 32'(mItem.cyc));
          checkOutput("memAddr", 32'(memAddr), 32'(mItem.addr));
          checkOutput("memRdWr", 32'({memWrite, memRead}), mItem.we ? 32'd2 : 32'd1);
          if (mItem.we) checkOutput("memWdata", 32'(memWdata), 32'(mItem.wdata));
        end
      end else begin
        checkOutput("memIdle", 32'({memAddr, memWdata}), 32'(0));
      end
      if (done != 3'b000) begin
        doneCount++;
        if (doneQ.size() == 0) begin
          checkOutput("doneUnexpected", 32'(done), 32'(0));
        end else begin
          dItem = doneQ.pop_front();
          checkOutput("doneCycle", 32'(cyc), 32'(dItem.cyc));
          checkOutput("doneWho", 32'(done), 32'(dItem.done));
          checkOutput("rdata", 32'(rdata), 32'(dItem.rdata));
        end
      end

      if (cyc >= nextArb) begin
        if (reqV[0] || reqV[1] || reqV[2]) begin
          if (starve == STARVE_LIMIT && reqV[2]) winner = 2;
          else if (reqV[0]) winner = 0;
          else if (reqV[1]) winner = 1;
          else winner = 2;
          if (winner == 2 || !reqV[2]) starve = 0;
          else if (starve < STARVE_LIMIT) starve++;
          winWe = (winner == 2) ? 1'b0 : weV[winner];
          memQ.push_back('{cyc + 1, winWe, addrV[winner], wdataV[winner]});
          grantCyc = cyc;
          if (winWe) begin
            pendValid = 1'b1;
            pendCyc   = cyc + 2;
            pendAddr  = addrV[winner];
            pendData  = wdataV[winner];
            doneQ.push_back('{cyc + 2, 3'(1 << winner), lastRead});
            nextArb = cyc + 3;
          end else begin
            readVal  = refMem[addrV[winner]];
            lastRead = readVal;
            doneQ.push_back('{cyc + 3, 3'(1 << winner), readVal});
            nextArb = cyc + 4;
          end
        end else begin
          starve = 0;
        end
      end
    end
  end

  // Raise a request, hold it until its done pulse, then drop it at the following edge.
  task automatic applyStimulus(input int id, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    weV[id]    = (id == 2) ? 1'b0 : we;
    addrV[id]  = addr;
    wdataV[id] = wdata;
    reqV[id]   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[id]) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("reqDone%0d", id), 32'(got), 32'(1));
    @(posedge clk);
    #1;
    reqV[id] = 1'b0;
  endtask

  task automatic randomRequester(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      applyStimulus(id, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    end
  endtask

  int mark;
  bit seen;

  initial begin
    for (int i = 0; i < 3; i++) begin
      reqV[i] = 1'b0; weV[i] = 1'b0; addrV[i] = '0; wdataV[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      simMem[i] = 8'($urandom);
      refMem[i] = simMem[i];
    end
    simMem[8'h10] = 8'h3C;
    refMem[8'h10] = 8'h3C;

    // Reset held with random inputs, then released with nothing requested
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        reqV[j] = 1'($urandom_range(0, 1)); weV[j] = 1'($urandom_range(0, 1));
        addrV[j] = 8'($urandom); wdataV[j] = 8'($urandom);
      end
      @(posedge clk);
      #2;
      checkOutput("resetHold", 32'({done, rdata, busy, memRead, memWrite, memAddr, memWdata}), 32'(0));
    end
    for (int j = 0; j < 3; j++) reqV[j] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idleNoReq", 32'({done, rdata, busy, memRead, memWrite, memAddr, memWdata}), 32'(0));
    end

    applyStimulus(1, 1'b1, 8'h20, 8'hA5);
    applyStimulus(2, 1'b0, 8'h10, 8'h00);
    repeat (2) @(posedge clk);

    fork
      applyStimulus(0, 1'b1, 8'hFF, 8'h11);
      applyStimulus(1, 1'b0, 8'h40, 8'h00);
      applyStimulus(2, 1'b0, 8'h00, 8'h00);
    join
    repeat (3) @(posedge clk);

    // Fetch held while stack and data keep re-requesting back to back
    mark = doneCount;
    fork
      repeat (3) applyStimulus(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      repeat (3) applyStimulus(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      begin
        applyStimulus(2, 1'b0, 8'($urandom_range(0, 15)), 8'h00);
        checkOutput("starveGrants", 32'(doneCount - mark - 1), 32'(STARVE_LIMIT));
      end
    join
    repeat (3) @(posedge clk);

    // Reset lands in the middle of a write's ISSUE cycle
    @(posedge clk);
    #1;
    weV[1] = 1'b1; addrV[1] = 8'h33; wdataV[1] = 8'h5A; reqV[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (memWrite) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("issueSeen", 32'(seen), 32'(1));
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rstAsync", 32'({memWrite, memRead, busy, done}), 32'(0));
    reqV[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rstNoDone", 32'({done, busy, memWrite}), 32'(0));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1, 1'b0, 8'h33, 8'h00);

    fork
      randomRequester(0, 25);
      randomRequester(1, 25);
      randomRequester(2, 25);
    join

    repeat (6) @(posedge clk);
    checkOutput("memQEmpty", 32'(memQ.size()), 32'(0));
    checkOutput("doneQEmpty", 32'(doneQ.size()), 32'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_access_scheduler.md
Name: mem_access_scheduler

Overview:
Sequences every access to the single unified 8-bit memory on behalf of three requesters: stack controller, execute-stage data port and instruction fetch. It replaces combinational same-cycle muxing with a registered request/done handshake. Each access goes through a small FSM against a synchronous memory. Fixed priority is stack > data > fetch, with a starvation guard that forces a fetch grant after a bounded wait.

Parameters:
STARVE_LIMIT, 4, number of consecutive lost arbitrations with fetch pending before fetch is forced; legal range 1..15.
AW, 8, address width.
DW, 8, data width.

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
stk_req  in  1  stack access request; held until stk done pulse
stk_we  in  1  1 = write, 0 = read
stk_addr  in  AW  stack address
stk_wdata  in  DW  stack write data
dat_req  in  1  data access request
dat_we  in  1  1 = write
dat_addr  in  AW  data address
dat_wdata  in  DW  data write data
ifu_req  in  1  instruction fetch request (read only)
ifu_addr  in  AW  fetch address
done  out  3  one-hot completion pulse: [0] stack, [1] data, [2] fetch
rdata  out  DW  read data; valid while done is high for a read
busy  out  1  high when state != IDLE
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data; valid the cycle after mem_read

Behaviour:
- Reset values: done=0, rdata=0, busy=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. FSM=IDLE, starvation counter=0, grant register=none.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are decoded from flops; there is no combinational path from any req input to any mem_* output.
- IDLE: arbitrate on the sampled req inputs.
  - If any req is high, latch winner id, we, addr and wdata, then go to ISSUE.
  - Later changes to the winner's inputs are ignored until the next IDLE.
- ISSUE, one cycle:
  - Drive mem_addr and mem_wdata from the latched values.
  - Drive mem_write=we, mem_read=!we. Fetch is always a read.
  - Next state is RESP for a write, WAIT for a read.
- WAIT: mem_* outputs are 0. Capture mem_rdata into rdata at the end of the cycle, then go to RESP.
- RESP, one cycle: done[winner]=1, busy=1, then go to IDLE.
  - rdata holds its last value until the next read capture.
  - For writes, rdata is not updated.
- Latency from req sampled in IDLE at cycle N: write done at N+2, read done at N+3. Back-to-back throughput is one access per 3 cycles (write) or 4 cycles (read).
- Requester rule: a requester holds req until it sees done, then drops req at the following edge. A req high in IDLE is always a new request.
- Arbitration: stk > dat > ifu, unless starve_cnt == STARVE_LIMIT and ifu_req=1, in which case ifu wins.
- Starvation counter (4 bits):
  - In IDLE, with a grant made and ifu_req=1 but ifu not granted: increment, saturating at STARVE_LIMIT.
  - Clear when ifu is granted or when ifu_req=0 in IDLE.
  - Hold in all other states.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep requesting and are re-arbitrated on the next IDLE.
- No requests in IDLE: stay in IDLE, all outputs 0.
- Reset mid-operation: asynchronous return to reset values.
  - mem_write/mem_read drop immediately.
  - The in-flight access is abandoned and no done is issued.
  - Requesters re-request after reset.
- Address arithmetic: none; addresses pass through unmodified.

Decomposition:
- Package mem_sched_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_ISSUE=2'd1, S_WAIT=2'd2, S_RESP=2'd3;
  - requester indices REQ_STK=0, REQ_DAT=1, REQ_IFU=2;
  - starvation counter width constant (4).
- One combinational sub-module, mem_sched_picker, takes the three reqs plus a force_ifu flag and returns a one-hot grant.
- FSM, latches and counter stay in the top module.

Test Plan:
1. Hold reset=0 with random inputs -> all outputs 0, busy=0. Release reset with no reqs -> outputs stay 0.
2. dat_req=1, dat_we=1, addr=0x20, wdata=0xA5 sampled in cycle 0 -> cycle 1: mem_write=1, mem_addr=0x20, mem_wdata=0xA5. Cycle 2: done=3'b010. Cycle 3: busy=0.
3. ifu_req=1, ifu_addr=0x10, memory returns 0x3C the cycle after mem_read -> cycle 1: mem_read=1, mem_addr=0x10. Cycle 3: done=3'b100, rdata=0x3C.
4. stk (write 0xFF<-0x11), dat (read 0x40) and ifu (read 0x00) all raised together -> done order is stack, data, fetch. Each mem_addr matches its requester.
5. STARVE_LIMIT=4, dat_req re-raised every IDLE, ifu_req held high -> 4 data grants, then ifu granted at the 5th arbitration, then the counter returns to 0.
6. Write issued, reset driven to 0 during ISSUE -> mem_write falls immediately without waiting for a clock edge, no done pulse. After release, busy=0 and a new request completes normally.
